// File: rtl/serializer_rr_scheduler.sv
// Round-robin owner of one shared serializer: grants one requester word at a time and frees the
// serializer after exactly LENGTH accepted serial bits, or after TIMEOUT cycles without a load.
module serializer_rr_scheduler #(
   parameter int unsigned N       = 4,
   parameter int unsigned LENGTH  = 24,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_en,
   input  logic [N*LENGTH-1:0]    iv_req_data,
   input  logic [N-1:0]           iv_req_valid,
   output logic [N-1:0]           ov_req_ack,
   output logic [LENGTH-1:0]      ov_ser_din,
   output logic                   o_ser_din_valid,
   input  logic                   i_ser_loaded,
   input  logic                   i_ser_bit_valid,
   input  logic                   i_ser_bit_ready,
   output logic [$clog2(N)-1:0]   ov_grant_id,
   output logic                   o_busy,
   output logic                   o_timeout
);

   localparam int unsigned IDW = $clog2(N);
   localparam int unsigned BCW = $clog2(LENGTH) + 1;
   localparam int unsigned TOW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {StArb, StIssue, StDrain} state_t;

   state_t           r_state;
   logic [IDW-1:0]   r_ptr;
   logic [BCW-1:0]   r_bit_cnt;
   logic [TOW-1:0]   r_to_cnt;

   logic             w_hit;
   logic [IDW-1:0]   w_sel;
   logic [IDW-1:0]   w_next_ptr;

   function automatic logic [IDW-1:0] f_wrap(input int unsigned v);
      return IDW'(v % N);
   endfunction

   // First valid requester at or after the pointer, wrapping N-1 -> 0.
   always_comb begin
      w_hit = 1'b0;
      w_sel = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (!w_hit && iv_req_valid[f_wrap(32'(r_ptr) + 32'(i))]) begin
            w_hit = 1'b1;
            w_sel = f_wrap(32'(r_ptr) + 32'(i));
         end
      end
   end

   assign w_next_ptr = f_wrap(32'(ov_grant_id) + 32'd1);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state         <= StArb;
         r_ptr           <= '0;
         r_bit_cnt       <= '0;
         r_to_cnt        <= '0;
         ov_req_ack      <= '0;
         ov_ser_din      <= '0;
         o_ser_din_valid <= 1'b0;
         ov_grant_id     <= '0;
         o_busy          <= 1'b0;
         o_timeout       <= 1'b0;
      end else if (i_en) begin
         ov_req_ack <= '0;
         o_timeout  <= 1'b0;
         case (r_state)
            StArb: begin
               if (w_hit) begin
                  ov_ser_din      <= iv_req_data[w_sel*LENGTH +: LENGTH];
                  ov_req_ack      <= N'(1) << w_sel;
                  ov_grant_id     <= w_sel;
                  o_ser_din_valid <= 1'b1;
                  o_busy          <= 1'b1;
                  r_to_cnt        <= '0;
                  r_state         <= StIssue;
               end
            end
            StIssue: begin
               if (i_ser_loaded) begin
                  o_ser_din_valid <= 1'b0;
                  r_bit_cnt       <= '0;
                  r_state         <= StDrain;
               end else if (r_to_cnt == TOW'(TIMEOUT - 1)) begin
                  // Serializer never took the word: drop it and move past this requester.
                  o_timeout       <= 1'b1;
                  o_ser_din_valid <= 1'b0;
                  o_busy          <= 1'b0;
                  r_ptr           <= w_next_ptr;
                  r_state         <= StArb;
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
            end
            StDrain: begin
               if (i_ser_bit_valid && i_ser_bit_ready) begin
                  if (r_bit_cnt == BCW'(LENGTH - 1)) begin
                     o_busy  <= 1'b0;
                     r_ptr   <= w_next_ptr;
                     r_state <= StArb;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end
            end
            default: begin
               o_ser_din_valid <= 1'b0;
               o_busy          <= 1'b0;
               r_state         <= StArb;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serializer_rr_scheduler.sv
// Bench for serializer_rr_scheduler: a serializer stand-in, a transaction-level model checked
// every cycle, and directed scenarios with hand-computed expectations.
module tb_serializer_rr_scheduler;

   localparam int N       = 4;
   localparam int L       = 24;
   localparam int TIMEOUT = 15;
   localparam int LOAD_DLY = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              en;
   logic [N*L-1:0]    req_data;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      ack;
   logic [L-1:0]      din;
   logic              dv;
   logic              ser_loaded;
   logic              bit_valid;
   bit                ready;
   logic [1:0]        gid;
   logic              busy;
   logic              tmo;

   serializer_rr_scheduler #(.N(N), .LENGTH(L), .TIMEOUT(TIMEOUT)) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_en            (en),
      .iv_req_data     (req_data),
      .iv_req_valid    (req_valid),
      .ov_req_ack      (ack),
      .ov_ser_din      (din),
      .o_ser_din_valid (dv),
      .i_ser_loaded    (ser_loaded),
      .i_ser_bit_valid (bit_valid),
      .i_ser_bit_ready (ready),
      .ov_grant_id     (gid),
      .o_busy          (busy),
      .o_timeout       (tmo)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_tot  = 0;
   bit chk_on = 1'b0;
   bit bp_mode = 1'b0;
   bit s_connected = 1'b1;
   int cyc = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      else n_pass++;
   endtask

   function automatic logic [L-1:0] dword(input int k);
      return req_data[k*L +: L];
   endfunction

   // Serializer stand-in: loads LOAD_DLY+1 cycles after seeing a word, then shifts LSB first.
   int         s_st = 0;
   int         s_dly;
   int         s_bits;
   logic [L-1:0] s_sh;
   assign bit_valid = (s_st == 2) && (s_bits > 0);

   int           nb = 0;
   logic [L-1:0] w_acc;
   logic [L-1:0] words_q[$];
   int           word_cyc_q[$];

   always @(posedge clk) begin
      if (rst) begin
         s_st       <= 0;
         ser_loaded <= 1'b0;
         nb = 0;
      end else if (en) begin
         case (s_st)
            0: if (dv && s_connected) begin s_dly <= LOAD_DLY; s_st <= 1; end
            1: if (s_dly == 0) begin
                  ser_loaded <= 1'b1;
                  s_sh       <= din;
                  s_bits     <= L;
                  s_st       <= 3;
               end else s_dly <= s_dly - 1;
            3: begin ser_loaded <= 1'b0; s_st <= 2; end
            default: if (s_bits > 0 && ready) begin
                  w_acc[nb] = s_sh[0];
                  nb++;
                  if (nb == L) begin words_q.push_back(w_acc); word_cyc_q.push_back(cyc); nb = 0; end
                  s_sh   <= s_sh >> 1;
                  s_bits <= s_bits - 1;
                  if (s_bits == 1) s_st <= 0;
               end
         endcase
      end
   end

   always @(posedge clk) begin
      #1;
      ready = bp_mode ? !ready : 1'b1;
   end

   // Transaction-level model: who owns the serializer, how long it waited, how many bits left.
   int           m_phase, m_ptr, m_owner, m_age, m_beats, m_gid, found;
   logic [N-1:0] m_ack;
   logic [L-1:0] m_din;
   bit           m_dv, m_busy, m_to;

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0; m_ptr = 0; m_owner = 0; m_age = 0; m_beats = 0; m_gid = 0;
         m_ack = '0; m_din = '0; m_dv = 0; m_busy = 0; m_to = 0;
      end else if (en) begin
         m_ack = '0;
         m_to  = 0;
         if (m_phase == 0) begin
            found = -1;
            for (int i = 0; i < N; i++)
               if (found < 0 && req_valid[(m_ptr + i) % N]) found = (m_ptr + i) % N;
            if (found >= 0) begin
               m_owner = found; m_gid = found; m_ack = N'(1) << found;
               m_din = req_data[found*L +: L]; m_dv = 1; m_busy = 1; m_age = 0; m_phase = 1;
            end
         end else if (m_phase == 1) begin
            m_age++;
            if (ser_loaded) begin m_dv = 0; m_beats = 0; m_phase = 2; end
            else if (m_age >= TIMEOUT) begin
               m_to = 1; m_dv = 0; m_busy = 0; m_ptr = (m_owner + 1) % N; m_phase = 0;
            end
         end else begin
            if (bit_valid && ready) m_beats++;
            if (m_beats == L) begin m_busy = 0; m_ptr = (m_owner + 1) % N; m_phase = 0; end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("ack", ack, m_ack);
         chk("ser_din", din, m_din);
         chk("ser_din_valid", dv, m_dv);
         chk("busy", busy, m_busy);
         chk("timeout", tmo, m_to);
         if (m_busy) chk("grant_id", gid, m_gid);
      end
   end

   // Event log used by the directed scenarios.
   int           grant_q[$], grant_cyc_q[$], rel_cyc_q[$], to_cyc_q[$];
   int           ack_hi = 0;
   logic [N-1:0] last_ack, prev_ack = '0;
   logic         prev_busy = 1'b0, prev_to = 1'b0;

   always @(negedge clk) begin
      if (ack != '0 && prev_ack == '0) begin
         for (int k = 0; k < N; k++) if (ack[k]) grant_q.push_back(k);
         grant_cyc_q.push_back(cyc);
         last_ack = ack;
      end
      if (ack != '0) ack_hi++;
      if (!busy && prev_busy) rel_cyc_q.push_back(cyc);
      if (tmo && !prev_to) to_cyc_q.push_back(cyc);
      prev_ack  = ack;
      prev_busy = busy;
      prev_to   = tmo;
      cyc++;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic int qsize(input int which);
      case (which)
         0: return grant_q.size();
         1: return rel_cyc_q.size();
         default: return to_cyc_q.size();
      endcase
   endfunction

   task automatic wait_q(input string name, input int which, input int target, input int budget);
      int b = 0;
      while (qsize(which) < target && b < budget) begin tick(); b++; end
      chk(name, qsize(which) >= target, 1);
   endtask

   int gb, rb, wb, tb0, ab, t2_ord[5];

   initial begin
      t2_ord = '{0, 1, 2, 3, 0};
      rst = 1'b1; en = 1'b1; req_valid = '0;
      req_data = {24'h0F1E2D, 24'hA5C3F0, 24'h9ABCDE, 24'h123456};
      tick(); tick();
      chk_on = 1'b1;
      chk("rst_busy", busy, 0);
      chk("rst_din_valid", dv, 0);
      chk("rst_ack", ack, 0);
      chk("rst_din", din, 0);
      rst = 1'b0;

      // All requesters held valid: strict rotation, each word drained before the next ack.
      gb = grant_q.size(); rb = rel_cyc_q.size(); wb = words_q.size();
      req_valid = 4'b1111;
      wait_q("t2_grants", 0, gb + 5, 400);
      req_valid = '0;
      wait_q("t2_release", 1, rb + 5, 100);
      for (int i = 0; i < 5; i++) chk("t2_order", grant_q[gb + i], t2_ord[i]);
      for (int i = 0; i < 4; i++) chk("t2_serialised", grant_cyc_q[gb + i + 1] > rel_cyc_q[rb + i], 1);
      for (int i = 0; i < 5; i++) chk("t2_word", words_q[wb + i], dword(t2_ord[i]));

      // Single request from requester 2.
      gb = grant_q.size(); rb = rel_cyc_q.size(); wb = words_q.size(); ab = ack_hi;
      req_valid = 4'b0100;
      wait_q("t1_grant", 0, gb + 1, 50);
      req_valid = '0;
      wait_q("t1_release", 1, rb + 1, 100);
      chk("t1_ack_value", last_ack, 4'b0100);
      chk("t1_ack_cycles", ack_hi - ab, 1);
      chk("t1_grant_id", grant_q[gb], 2);
      chk("t1_word", words_q[wb], 24'hA5C3F0);
      chk("t1_release_on_last_bit", rel_cyc_q[rb], word_cyc_q[wb]);
      chk("t1_latency", rel_cyc_q[rb] - grant_cyc_q[gb], 29);

      // Backpressure: bit_ready toggles every cycle.
      gb = grant_q.size(); rb = rel_cyc_q.size(); wb = words_q.size();
      bp_mode = 1'b1;
      req_valid = 4'b0001;
      wait_q("t3_grant", 0, gb + 1, 50);
      req_valid = '0;
      wait_q("t3_release", 1, rb + 1, 200);
      bp_mode = 1'b0;
      chk("t3_grant_id", grant_q[gb], 0);
      chk("t3_word", words_q[wb], dword(0));
      chk("t3_release_on_last_bit", rel_cyc_q[rb], word_cyc_q[wb]);
      chk("t3_stretched", rel_cyc_q[rb] - grant_cyc_q[gb] >= 50, 1);

      // Timeout: serializer never loads requester 1's word; next search starts at 2.
      gb = grant_q.size(); rb = rel_cyc_q.size(); wb = words_q.size(); tb0 = to_cyc_q.size();
      s_connected = 1'b0;
      req_valid = 4'b1010;
      wait_q("t4_timeout", 2, tb0 + 1, 100);
      s_connected = 1'b1;
      req_valid = 4'b1000;
      wait_q("t4_regrant", 0, gb + 2, 20);
      req_valid = '0;
      wait_q("t4_release", 1, rb + 2, 100);
      chk("t4_first_grant", grant_q[gb], 1);
      chk("t4_timeout_delay", to_cyc_q[tb0] - grant_cyc_q[gb], 15);
      chk("t4_busy_drop_at_timeout", rel_cyc_q[rb], to_cyc_q[tb0]);
      chk("t4_next_grant", grant_q[gb + 1], 3);
      chk("t4_word", words_q[wb], dword(3));

      // Reset at bit 10 of a drain, then a fresh grant must start from requester 0.
      gb = grant_q.size(); tb0 = to_cyc_q.size();
      req_valid = 4'b0100;
      wait_q("t5_grant", 0, gb + 1, 50);
      req_valid = '0;
      for (int b = 0; b < 100 && nb < 10; b++) tick();
      chk("t5_reached_bit10", nb, 10);
      rst = 1'b1;
      tick();
      chk("t5_busy", busy, 0);
      chk("t5_din_valid", dv, 0);
      chk("t5_ack", ack, 0);
      chk("t5_din", din, 0);
      chk("t5_grant_id", gid, 0);
      chk("t5_timeout", tmo, 0);
      rst = 1'b0;
      chk("t5_no_timeout_pulse", to_cyc_q.size(), tb0);

      // Clock enable low for 5 cycles during ISSUE shifts completion by exactly 5 cycles.
      gb = grant_q.size(); rb = rel_cyc_q.size(); wb = words_q.size();
      req_valid = 4'b1111;
      wait_q("t6_grant", 0, gb + 1, 20);
      req_valid = '0;
      tick();
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t6_frozen_din_valid", dv, 1);
         chk("t6_frozen_busy", busy, 1);
      end
      en = 1'b1;
      wait_q("t6_release", 1, rb + 1, 100);
      chk("t5_grant_after_reset", grant_q[gb], 0);
      chk("t6_latency", rel_cyc_q[rb] - grant_cyc_q[gb], 34);
      chk("t6_word", words_q[wb], dword(0));

      tick(); tick();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_tot);
      $fatal(1, "watchdog");
   end

endmodule
